reg_file_wb: RTL and testbench

- Register file and write-back stage for the 8-bit single-cycle processor.
- Sits directly upstream of the ALU and supplies its A operand from the selected source register.
- Also sits downstream of the ALU: it captures ALU_Res into the destination register on the clock edge, which completes the single-cycle datapath loop.
- Provides a second read port for debug/store data, a write-counter for bench visibility, and an optional read-after-write bypass.

---
 rtl/reg_file_wb.sv | 70 +++++++
 tb/tb_reg_file_wb.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
// Register file + write-back stage: two combinational read ports, one write per clk edge, commit counter.
// Optional REGFILE_BYPASS_EN forwards same-cycle wb_data to matching read ports; no handshake, never stalls.
module reg_file_wb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [7:0]        wb_count,
  output logic [ADDR_W-1:0] wb_last_addr
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [7:0]        r_wb_count;
  logic [ADDR_W-1:0] r_wb_last_addr;

  logic              w_commit;
  logic              w_rs_zero;
  logic              w_rt_zero;
  logic [DATA_W-1:0] w_rs_stored;
  logic [DATA_W-1:0] w_rt_stored;

  // Writes to r0 are dropped entirely (not stored, not counted) when ZERO_REG is set.
  assign w_commit  = wb_en && !((ZERO_REG != 0) && (rd_addr == '0));
  assign w_rs_zero = (ZERO_REG != 0) && (rs_addr == '0);
  assign w_rt_zero = (ZERO_REG != 0) && (rt_addr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wb_count     <= '0;
      r_wb_last_addr <= '0;
    end else if (w_commit) begin
      r_regs[rd_addr] <= wb_data;
      r_wb_count      <= r_wb_count + 8'd1;
      r_wb_last_addr  <= rd_addr;
    end
  end

  assign w_rs_stored = w_rs_zero ? '0 : r_regs[rs_addr];
  assign w_rt_stored = w_rt_zero ? '0 : r_regs[rt_addr];

`ifdef REGFILE_BYPASS_EN
  logic w_rs_byp;
  logic w_rt_byp;

  assign w_rs_byp = w_commit && !reset && (rd_addr == rs_addr);
  assign w_rt_byp = w_commit && !reset && (rd_addr == rt_addr);
  assign rs_data  = w_rs_byp ? wb_data : w_rs_stored;
  assign rt_data  = w_rt_byp ? wb_data : w_rt_stored;
`else
  assign rs_data  = w_rs_stored;
  assign rt_data  = w_rt_stored;
`endif

  assign wb_count     = r_wb_count;
  assign wb_last_addr = r_wb_last_addr;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: one instance with ZERO_REG=0 (u_dut) and one with ZERO_REG=1 (u_dz), shared inputs.
module tb_reg_file_wb;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rs_addr, rt_addr, rd_addr;
  logic       wb_en;
  logic [7:0] wb_data;

  logic [7:0] rs0, rt0, cnt0;
  logic [2:0] last0;
  logic [7:0] rs1, rt1, cnt1;
  logic [2:0] last1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_file_wb #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8), .ZERO_REG(0)) u_dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .wb_en(wb_en), .wb_data(wb_data), .rs_data(rs0), .rt_data(rt0),
    .wb_count(cnt0), .wb_last_addr(last0)
  );

  reg_file_wb #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8), .ZERO_REG(1)) u_dz (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .wb_en(wb_en), .wb_data(wb_data), .rs_data(rs1), .rt_data(rt1),
    .wb_count(cnt1), .wb_last_addr(last1)
  );

  // Inputs change 2 time units after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; wb_en = 1'b1; rd_addr = 3'd3; wb_data = 8'hAA;
    rs_addr = 3'd3; rt_addr = 3'd3;
    tick();
    tick();
    #1;
    n_checks++; if (rs0 !== 8'h00) $display("FAIL reset_rs_during got=%h exp=00", rs0); else n_pass++;
    n_checks++; if (cnt0 !== 8'd0) $display("FAIL reset_cnt_during got=%0d exp=0", cnt0); else n_pass++;
    reset = 1'b0; wb_en = 1'b0;
    tick();
    #1;
    n_checks++; if (rt0 !== 8'h00) $display("FAIL reset_r3_after got=%h exp=00", rt0); else n_pass++;
    n_checks++; if (cnt0 !== 8'd0 || last0 !== 3'd0) $display("FAIL reset_cnt_last_after got=%0d/%0d exp=0/0", cnt0, last0); else n_pass++;
  endtask

  task automatic test_write_readback();
    logic [7:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 8'h5C;
`else
    exp_same = 8'h00;
`endif
    rd_addr = 3'd5; wb_data = 8'h5C; wb_en = 1'b1; rs_addr = 3'd5; rt_addr = 3'd5;
    #1;
    n_checks++; if (rs0 !== exp_same) $display("FAIL wr_same_cycle got=%h exp=%h", rs0, exp_same); else n_pass++;
    tick();
    wb_en = 1'b0;
    #1;
    n_checks++; if (rs0 !== 8'h5C || rt0 !== 8'h5C) $display("FAIL wr_readback got=%h/%h exp=5c/5c", rs0, rt0); else n_pass++;
    n_checks++; if (cnt0 !== 8'd1 || last0 !== 3'd5) $display("FAIL wr_cnt_last got=%0d/%0d exp=1/5", cnt0, last0); else n_pass++;
  endtask

  task automatic test_disabled_write();
    wb_en = 1'b0; rd_addr = 3'd2; wb_data = 8'hFF; rs_addr = 3'd2; rt_addr = 3'd5;
    repeat (4) tick();
    #1;
    n_checks++; if (rs0 !== 8'h00) $display("FAIL dis_r2 got=%h exp=00", rs0); else n_pass++;
    n_checks++; if (cnt0 !== 8'd1 || last0 !== 3'd5) $display("FAIL dis_cnt_last got=%0d/%0d exp=1/5", cnt0, last0); else n_pass++;
  endtask

  task automatic test_zero_reg();
    rd_addr = 3'd0; wb_data = 8'h77; wb_en = 1'b1; rs_addr = 3'd0; rt_addr = 3'd0;
    #1;
    n_checks++; if (rs1 !== 8'h00) $display("FAIL zr_same_cycle got=%h exp=00", rs1); else n_pass++;
    tick();
    wb_en = 1'b0;
    #1;
    n_checks++; if (rs1 !== 8'h00 || rt1 !== 8'h00) $display("FAIL zr_read got=%h/%h exp=00/00", rs1, rt1); else n_pass++;
    n_checks++; if (cnt1 !== 8'd1 || last1 !== 3'd5) $display("FAIL zr_cnt_last got=%0d/%0d exp=1/5", cnt1, last1); else n_pass++;
    n_checks++; if (rs0 !== 8'h77 || cnt0 !== 8'd2 || last0 !== 3'd0) $display("FAIL nz_r0_write got=%h/%0d/%0d exp=77/2/0", rs0, cnt0, last0); else n_pass++;
  endtask

  task automatic test_counter_wrap();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    rd_addr = 3'd1; rs_addr = 3'd1; rt_addr = 3'd1; wb_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wb_data = i[7:0];
      tick();
    end
    #1;
    n_checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) $display("FAIL wrap_256 got=%0d/%0d exp=0/0", cnt0, cnt1); else n_pass++;
    n_checks++; if (rs0 !== 8'hFF) $display("FAIL wrap_r1_mid got=%h exp=ff", rs0); else n_pass++;
    wb_data = 8'h00;
    tick();
    wb_en = 1'b0;
    #1;
    n_checks++; if (cnt0 !== 8'd1 || cnt1 !== 8'd1) $display("FAIL wrap_257 got=%0d/%0d exp=1/1", cnt0, cnt1); else n_pass++;
    n_checks++; if (rs1 !== 8'h00 || last0 !== 3'd1) $display("FAIL wrap_r1_last got=%h/%0d exp=00/1", rs1, last0); else n_pass++;
  endtask

  task automatic test_async_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    wb_en = 1'b1;
    for (int i = 1; i < 8; i++) begin
      rd_addr = 3'(i);
      wb_data = 8'(i * 8'h11);
      tick();
    end
    wb_en = 1'b0; rs_addr = 3'd1; rt_addr = 3'd7;
    #1;
    n_checks++; if (rs0 !== 8'h11 || rt0 !== 8'h77 || cnt0 !== 8'd7) $display("FAIL ar_loaded got=%h/%h/%0d exp=11/77/7", rs0, rt0, cnt0); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (rs0 !== 8'h00 || rt0 !== 8'h00 || rt1 !== 8'h00) $display("FAIL ar_during got=%h/%h/%h exp=00/00/00", rs0, rt0, rt1); else n_pass++;
    n_checks++; if (cnt0 !== 8'd0 || last0 !== 3'd0) $display("FAIL ar_cnt_last got=%0d/%0d exp=0/0", cnt0, last0); else n_pass++;
    reset = 1'b0;
    rt_addr = 3'd4;
    #1;
    n_checks++; if (rt0 !== 8'h00) $display("FAIL ar_r4_after got=%h exp=00", rt0); else n_pass++;
    rd_addr = 3'd4; wb_data = 8'h3C; wb_en = 1'b1;
    tick();
    wb_en = 1'b0;
    #1;
    n_checks++; if (rt0 !== 8'h3C || cnt0 !== 8'd1 || last0 !== 3'd4) $display("FAIL ar_first_edge got=%h/%0d/%0d exp=3c/1/4", rt0, cnt0, last0); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; wb_en = 1'b0; rd_addr = '0; rs_addr = '0; rt_addr = '0; wb_data = '0;
    test_reset();
    test_write_readback();
    test_disabled_write();
    test_zero_reg();
    test_counter_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
